heading_servo_ctrl: RTL

- Downstream of detect_direction: consumes its per-frame heading (direction, no_red) and drives the robot's pan servo with a 50 Hz PWM signal.
- Maps heading 0..FOV linearly onto a pulse-width range.
- Applies a slew limit so the servo never jumps, and runs a small track / hold / idle state machine for loss of target.
- Updates the pulse width only at PWM period boundaries, so no pulse is ever truncated or glitched.

---
 rtl/servo_pkg.sv | 19 +
 rtl/heading_servo_ctrl_if.sv | 18 +
 rtl/pwm_gen.sv | 49 ++++
 rtl/heading_servo_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared types and default timing constants for the heading servo controller.
//   servo_state_t : tracking state machine encoding (IDLE / TRACK / HOLD)
//   DEF_*         : default PWM timing for a 50 MHz clock and a 50 Hz servo
// -----------------------------------------------------------------------------
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } servo_state_t;

    localparam int DEF_PERIOD    = 1_000_000;  // 20 ms at 50 MHz
    localparam int DEF_MIN_PULSE = 50_000;     // 1 ms
    localparam int DEF_MAX_PULSE = 100_000;    // 2 ms

endpackage

// File: rtl/heading_servo_ctrl_if.sv
// -----------------------------------------------------------------------------
// heading_servo_ctrl_if
// Per-frame heading report from detect_direction to the servo controller.
//   frame_done : single-cycle strobe, direction/no_red valid in that cycle
//   direction  : unsigned heading 0..FOV
//   no_red     : 1 = frame contained no red target
// Modports: master (heading source), slave (servo controller).
// -----------------------------------------------------------------------------
interface heading_servo_ctrl_if;

    logic       frame_done;
    logic [4:0] direction;
    logic       no_red;

    modport master (output frame_done, output direction, output no_red);
    modport slave  (input  frame_done, input  direction, input  no_red);

endinterface

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
// Free-running period counter with a registered width compare.
//   clk, reset  : clock, synchronous active-high reset
//   pulse_width : high time in clk cycles, sampled continuously
//   pwm_out     : registered (period_cnt < pulse_width), one cycle behind
//   period_end  : high in the last cycle of each period (period_cnt==PERIOD-1)
// -----------------------------------------------------------------------------
module pwm_gen
    import servo_pkg::*;
#(
    parameter int PERIOD   = DEF_PERIOD,
    parameter int CNT_BITS = $clog2(PERIOD)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CNT_BITS-1:0] pulse_width,
    output logic                pwm_out,
    output logic                period_end
);

    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(PERIOD - 1);

    logic [CNT_BITS-1:0] period_cnt_q, period_cnt_d;
    logic                pwm_q, pwm_d;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        period_end   = (period_cnt_q == LAST_CNT);
        period_cnt_d = period_end ? '0 : period_cnt_q + CNT_BITS'(1);
        pwm_d        = (period_cnt_q < pulse_width);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt_q <= '0;
            pwm_q        <= 1'b0;
        end else begin
            period_cnt_q <= period_cnt_d;
            pwm_q        <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/heading_servo_ctrl.sv
// -----------------------------------------------------------------------------
// heading_servo_ctrl
// Turns per-frame headings into a slew-limited 50 Hz servo PWM.
//   clk, reset  : clock, synchronous active-high reset
//   hdg         : heading_servo_ctrl_if.slave (frame_done, direction, no_red)
//   pwm_out     : servo PWM
//   pulse_width : pulse width currently applied (changes only at period ends)
//   state       : 0 IDLE, 1 TRACK, 2 HOLD
//   locked      : TRACK and pulse_width has reached the target
// Optional build macro HEADING_SERVO_SWEEP_EN: while IDLE the target sweeps
// between MIN_PULSE and MAX_PULSE by SLEW per period instead of parking at
// the centre.
// -----------------------------------------------------------------------------
module heading_servo_ctrl
    import servo_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int PERIOD      = CLK_HZ / 50,
    parameter int MIN_PULSE   = DEF_MIN_PULSE,
    parameter int MAX_PULSE   = DEF_MAX_PULSE,
    parameter int FOV         = 25,
    parameter int SLEW        = 5_000,
    parameter int LOST_FRAMES = 8,
    parameter int CNT_BITS    = $clog2(PERIOD)
) (
    input  logic                   clk,
    input  logic                   reset,
    heading_servo_ctrl_if.slave    hdg,
    output logic                   pwm_out,
    output logic [CNT_BITS-1:0]    pulse_width,
    output logic [1:0]             state,
    output logic                   locked
);

    localparam int STEP_PER_DEG = (MAX_PULSE - MIN_PULSE) / FOV;
    localparam int CENTRE       = (MIN_PULSE + MAX_PULSE) / 2;
    localparam int MUL_BITS     = CNT_BITS + 5;
    localparam int LOST_BITS    = $clog2(LOST_FRAMES + 1);

    localparam logic [CNT_BITS-1:0]  CENTRE_W = CNT_BITS'(CENTRE);
    localparam logic [CNT_BITS-1:0]  SLEW_W   = CNT_BITS'(SLEW);
    localparam logic [4:0]           FOV_W    = 5'(FOV);
    localparam logic [MUL_BITS-1:0]  STEP_M   = MUL_BITS'(STEP_PER_DEG);
    localparam logic [MUL_BITS-1:0]  MIN_M    = MUL_BITS'(MIN_PULSE);
    localparam logic [LOST_BITS-1:0] LOST_W   = LOST_BITS'(LOST_FRAMES);

    servo_state_t         state_q, state_d;
    logic [CNT_BITS-1:0]  pulse_width_q, pulse_width_d;
    logic [CNT_BITS-1:0]  target_q, target_d;
    logic [LOST_BITS-1:0] lost_cnt_q, lost_cnt_d, lost_inc;
    logic [4:0]           dir_clamped;
    logic [CNT_BITS-1:0]  mapped_target;
    logic [CNT_BITS-1:0]  slewed;
    logic                 period_end;

`ifdef HEADING_SERVO_SWEEP_EN
    localparam logic [CNT_BITS-1:0] MIN_W = CNT_BITS'(MIN_PULSE);
    localparam logic [CNT_BITS-1:0] MAX_W = CNT_BITS'(MAX_PULSE);
    logic sweep_up_q, sweep_up_d;
`endif

    pwm_gen #(
        .PERIOD   (PERIOD),
        .CNT_BITS (CNT_BITS)
    ) u_pwm_gen (
        .clk         (clk),
        .reset       (reset),
        .pulse_width (pulse_width_q),
        .pwm_out     (pwm_out),
        .period_end  (period_end)
    );

    // Heading to pulse width; the product is formed at MUL_BITS so the
    // largest heading times the step cannot wrap before truncation.
    always_comb begin
        dir_clamped   = (hdg.direction > FOV_W) ? FOV_W : hdg.direction;
        mapped_target = CNT_BITS'(MIN_M + MUL_BITS'(dir_clamped) * STEP_M);
    end

    // Slew limiter: step toward target by at most SLEW, landing exactly on it.
    // Only committed at the period boundary so a pulse is never cut short.
    always_comb begin
        slewed = pulse_width_q;
        if (target_q > pulse_width_q) begin
            slewed = ((target_q - pulse_width_q) > SLEW_W) ? pulse_width_q + SLEW_W : target_q;
        end else if (target_q < pulse_width_q) begin
            slewed = ((pulse_width_q - target_q) > SLEW_W) ? pulse_width_q - SLEW_W : target_q;
        end
        pulse_width_d = period_end ? slewed : pulse_width_q;
    end

    // Track / hold / idle. A frame arriving on the boundary cycle updates
    // target_q at the same edge the slew reads it, so that boundary still
    // slews toward the old target.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        lost_cnt_d = lost_cnt_q;
        lost_inc   = lost_cnt_q + LOST_BITS'(1);
`ifdef HEADING_SERVO_SWEEP_EN
        sweep_up_d = sweep_up_q;
        if (state_q != IDLE) begin
            // Sweep always restarts upward from wherever IDLE is entered.
            sweep_up_d = 1'b1;
        end else if (period_end) begin
            if (sweep_up_q) begin
                if ((MAX_W - target_q) <= SLEW_W) begin
                    target_d   = MAX_W;
                    sweep_up_d = 1'b0;
                end else begin
                    target_d = target_q + SLEW_W;
                end
            end else begin
                if ((target_q - MIN_W) <= SLEW_W) begin
                    target_d   = MIN_W;
                    sweep_up_d = 1'b1;
                end else begin
                    target_d = target_q - SLEW_W;
                end
            end
        end
`endif
        if (hdg.frame_done) begin
            if (!hdg.no_red) begin
                state_d    = TRACK;
                lost_cnt_d = '0;
                target_d   = mapped_target;
            end else begin
                case (state_q)
                    TRACK: begin
                        state_d    = HOLD;
                        lost_cnt_d = LOST_BITS'(1);
                    end
                    HOLD: begin
                        if (lost_inc == LOST_W) begin
                            state_d    = IDLE;
                            target_d   = CENTRE_W;
                            lost_cnt_d = '0;
                        end else begin
                            lost_cnt_d = lost_inc;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pulse_width_q <= CENTRE_W;
            target_q      <= CENTRE_W;
            lost_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pulse_width_q <= pulse_width_d;
            target_q      <= target_d;
            lost_cnt_q    <= lost_cnt_d;
        end
    end

`ifdef HEADING_SERVO_SWEEP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_up_q <= 1'b1;
        end else begin
            sweep_up_q <= sweep_up_d;
        end
    end
`endif

    assign pulse_width = pulse_width_q;
    assign state       = state_q;
    assign locked      = (state_q == TRACK) && (pulse_width_q == target_q);

endmodule
